// File: rtl/present_key_sched_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// present_pkg
// Purpose : Shared definitions for the PRESENT-80 key schedule controller.
//           Holds the width constants, the 4-bit S-box and inverse S-box
//           lookups, and the controller state enum.
// Ports   : none (package)
// Config  : KSCHED_DECRYPT_EN adds the FWD state and its counter limit.
// ---------------------------------------------------------------------------
package present_pkg;

  localparam int KEY_W  = 80;
  localparam int RK_W   = 64;
  localparam int NUM_RK = 32;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_RK);
`ifdef KSCHED_DECRYPT_EN
  // FWD leaves after the step that consumes this counter value.
  localparam logic [CNT_W-1:0] CNT_FWD_LAST = CNT_W'(NUM_RK - 1);
`endif

`ifdef KSCHED_DECRYPT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FWD  = 2'd2
  } ksched_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1
  } ksched_state_t;
`endif

  // PRESENT 4-bit S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Inverse of the PRESENT S-box.
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// present_key_sched_ctrl_if
// Purpose : Groups the key-load request and the round-key stream between the
//           key schedule controller (slave) and its user (master).
// Signals : start, key_in        request a run with a master key
//           dec                  decrypt order request (KSCHED_DECRYPT_EN only)
//           busy                 controller not idle
//           rk_valid, rk_ready   round-key handshake
//           rk, rk_round         round key and its index 1..NUM_RK
//           done                 one-cycle pulse after the last round key
// Config  : KSCHED_DECRYPT_EN adds the dec signal.
// ---------------------------------------------------------------------------
interface present_key_sched_ctrl_if;
  import present_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
`ifdef KSCHED_DECRYPT_EN
  logic             dec;
`endif
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  logic [RK_W-1:0]  rk;
  logic [CNT_W-1:0] rk_round;
  logic             done;

  modport master (
    output start, key_in, rk_ready,
`ifdef KSCHED_DECRYPT_EN
    output dec,
`endif
    input  busy, rk_valid, rk, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
`ifdef KSCHED_DECRYPT_EN
    input  dec,
`endif
    output busy, rk_valid, rk, rk_round, done
  );

endinterface

// File: rtl/present_key_sched_ctrl_key_step.sv
// ---------------------------------------------------------------------------
// present_key_step
// Purpose : Combinational single-round PRESENT-80 key register update.
//           Forward: rotate left 61, S-box on [79:76], [19:15] ^= cnt.
//           Inverse: [19:15] ^= cnt-1, inverse S-box on [79:76], rotate
//           right 61 (undoes the forward step that produced round cnt).
// Ports   : key_i  current key register
//           cnt_i  low 5 bits of the round counter
//           inv_i  select the inverse step
//           key_o  updated key register
// Config  : inv_i is tied low by the controller when KSCHED_DECRYPT_EN is
//           undefined, which removes the inverse path.
// ---------------------------------------------------------------------------
module present_key_step
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       cnt_i,
  input  logic             inv_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] fwd_key;
  logic [KEY_W-1:0] inv_tmp;
  logic [KEY_W-1:0] inv_key;

  // Forward round update.
  always_comb begin
    fwd_key         = {key_i[18:0], key_i[79:19]};
    fwd_key[79:76]  = sbox(fwd_key[79:76]);
    fwd_key[19:15]  = fwd_key[19:15] ^ cnt_i;
  end

  // Inverse round update; the counter wraps in 5 bits, so cnt=32 yields 31.
  always_comb begin
    inv_tmp         = key_i;
    inv_tmp[19:15]  = inv_tmp[19:15] ^ (cnt_i - 5'd1);
    inv_tmp[79:76]  = sbox_inv(inv_tmp[79:76]);
    inv_key         = {inv_tmp[60:0], inv_tmp[79:61]};
  end

  assign key_o = inv_i ? inv_key : fwd_key;

endmodule

// File: rtl/present_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// present_key_sched_ctrl
// Purpose : Sequences the PRESENT-80 key schedule. Loads an 80-bit master key
//           on start, then streams round keys K1..K32 (rk = key_reg[79:16])
//           over a valid/ready handshake, stepping the key register once per
//           accepted round key. Emits a one-cycle done pulse at the end.
// Ports   : clk        clock
//           rst        synchronous active-high reset
//           bus        present_key_sched_ctrl_if.slave (start/key_in/dec,
//                      busy, rk_valid/rk_ready, rk, rk_round, done)
// Config  : KSCHED_DECRYPT_EN adds the dec request and the FWD state, which
//           pre-rolls the key to K32 and then streams K32..K1 using the
//           inverse step.
// ---------------------------------------------------------------------------
module present_key_sched_ctrl
  import present_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  present_key_sched_ctrl_if.slave bus
);

  ksched_state_t    state_q;
  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rk_valid_q;
  logic             done_q;

  logic [KEY_W-1:0] key_step_d;
  logic             step_inv;
  logic             last_rk;

`ifdef KSCHED_DECRYPT_EN
  logic dec_q;

  // Only the emit phase of a decrypt run walks the schedule backwards.
  assign step_inv = dec_q && (state_q == ST_EMIT);
  assign last_rk  = dec_q ? (cnt_q == CNT_FIRST) : (cnt_q == CNT_LAST);
`else
  assign step_inv = 1'b0;
  assign last_rk  = (cnt_q == CNT_LAST);
`endif

  present_key_step u_step (
    .key_i (key_q),
    .cnt_i (cnt_q[4:0]),
    .inv_i (step_inv),
    .key_o (key_step_d)
  );

  // Controller FSM. All outputs come straight from registers, so rk_valid
  // never depends combinationally on rk_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      cnt_q      <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef KSCHED_DECRYPT_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            key_q <= bus.key_in;
            cnt_q <= CNT_FIRST;
`ifdef KSCHED_DECRYPT_EN
            dec_q <= bus.dec;
            if (bus.dec) begin
              state_q <= ST_FWD;
            end else begin
              state_q    <= ST_EMIT;
              rk_valid_q <= 1'b1;
            end
`else
            state_q    <= ST_EMIT;
            rk_valid_q <= 1'b1;
`endif
          end
        end

`ifdef KSCHED_DECRYPT_EN
        // Roll the key forward to K32 without presenting anything; the
        // last step lands cnt on NUM_RK together with the switch to EMIT.
        ST_FWD: begin
          key_q <= key_step_d;
          cnt_q <= cnt_q + CNT_FIRST;
          if (cnt_q == CNT_FWD_LAST) begin
            state_q    <= ST_EMIT;
            rk_valid_q <= 1'b1;
          end
        end
`endif

        ST_EMIT: begin
          if (bus.rk_ready) begin
            if (last_rk) begin
              state_q    <= ST_IDLE;
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              key_q <= key_step_d;
`ifdef KSCHED_DECRYPT_EN
              cnt_q <= dec_q ? (cnt_q - CNT_FIRST) : (cnt_q + CNT_FIRST);
`else
              cnt_q <= cnt_q + CNT_FIRST;
`endif
            end
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          rk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk       = key_q[79:16];
  assign bus.rk_round = cnt_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_present_key_sched_ctrl
// Purpose : Self-checking bench for present_key_sched_ctrl. A bench-side
//           model computes the 32 round keys for a master key; a monitor
//           compares every valid round key, its index and the done pulse
//           against that model.
// Config  : KSCHED_DECRYPT_EN enables the decrypt-order run.
// ---------------------------------------------------------------------------
module tb_present_key_sched_ctrl;
  import present_pkg::*;

  logic clk = 1'b0;
  logic rst;

  present_key_sched_ctrl_if bus();

  present_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [3:0]  tbSbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] modelRk [1:32];

  // Monitor state shared with the stimulus.
  bit monEn      = 1'b0;
  bit decMode    = 1'b0;
  bit doneDue    = 1'b0;
  int nextRound  = 1;
  int hsCount    = 0;
  int validCycles = 0;
  int doneCount  = 0;
  int stallCycles = 0;

  task automatic checkOutput(input string name, input logic [79:0] actual,
                             input logic [79:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // One key-register round, written with plain shifts on an 80-bit value.
  function automatic logic [79:0] modelNext(input logic [79:0] k, input int r);
    logic [79:0] t;
    t = (k << 61) | (k >> 19);
    t[79:76] = tbSbox[t[79:76]];
    t[19:15] = t[19:15] ^ 5'(r);
    return t;
  endfunction

  task automatic buildModel(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      modelRk[r] = k[79:16];
      if (r < 32) k = modelNext(k, r);
    end
  endtask

  // Compare process: checks every cycle while a run is being observed.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("done_pulse", bus.done, doneDue);
      if (bus.done) doneCount++;
      doneDue = 1'b0;
      if (bus.rk_valid) begin
        validCycles++;
        checkOutput("busy_while_valid", bus.busy, 1);
        checkOutput("rk_round", bus.rk_round, nextRound);
        if (nextRound >= 1 && nextRound <= 32) begin
          checkOutput("rk_value", bus.rk, modelRk[nextRound]);
          if (bus.rk_ready) begin
            hsCount++;
            if ((decMode && nextRound == 1) || (!decMode && nextRound == 32))
              doneDue = 1'b1;
            nextRound = decMode ? nextRound - 1 : nextRound + 1;
          end else begin
            stallCycles++;
          end
        end else begin
          checkOutput("rk_valid_after_last", bus.rk_valid, 0);
        end
      end
    end
  end

  // Runs one schedule: start with key, optional stray start at round
  // startAt, optional reset at round resetAt.
  task automatic applyStimulus(input logic [79:0] key, input bit randomReady,
                               input int startAt, input int resetAt,
                               input bit dec, input int expLatency);
    int cycles;
    int firstValid;
    bit finished;
    bit aborted;
    bit injected;
    cycles = 0; firstValid = 0; finished = 1'b0; aborted = 1'b0; injected = 1'b0;
    hsCount = 0; validCycles = 0; doneCount = 0; stallCycles = 0; doneDue = 1'b0;
    decMode = dec;
    nextRound = dec ? 32 : 1;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.key_in   = key;
`ifdef KSCHED_DECRYPT_EN
    bus.dec      = dec;
`endif
    bus.rk_ready = 1'b1;
    monEn        = 1'b1;
    while (!finished && !aborted && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      bus.start    = 1'b0;
      bus.rk_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (startAt != 0 && !injected && nextRound == startAt) begin
        bus.start  = 1'b1;
        bus.key_in = ~key;
        injected   = 1'b1;
      end
      if (resetAt != 0 && nextRound == resetAt) begin
        monEn = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        aborted = 1'b1;
        @(negedge clk);
        checkOutput("reset_rk_valid", bus.rk_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_rk_round", bus.rk_round, 0);
        checkOutput("reset_done", bus.done, 0);
      end else begin
        @(negedge clk);
        if (bus.rk_valid && firstValid == 0) firstValid = cycles;
        if (bus.done) finished = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (!aborted) begin
      checkOutput("run_finished", finished, 1);
      @(negedge clk);
      @(posedge clk); #1;
      monEn = 1'b0;
      checkOutput("first_valid_latency", firstValid, expLatency);
      checkOutput("handshake_count", hsCount, 32);
      checkOutput("done_count", doneCount, 1);
      if (randomReady) checkOutput("stall_seen", stallCycles > 0, 1);
      else             checkOutput("valid_cycles", validCycles, 32);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
`ifdef KSCHED_DECRYPT_EN
    bus.dec      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: everything quiet.
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_rk_valid", bus.rk_valid, 0);
    checkOutput("idle_rk", bus.rk, 0);
    checkOutput("idle_rk_round", bus.rk_round, 0);
    checkOutput("idle_done", bus.done, 0);

    // Pin the model with hand-derived round keys for the all-zero key.
    buildModel(80'h0);
    checkOutput("model_K1", modelRk[1], 64'h0);
    checkOutput("model_K2", modelRk[2], 64'hC000_0000_0000_0000);
    checkOutput("model_K3", modelRk[3], 64'h5000_1800_0000_0001);

    $display("[TB] zero key, ready held high");
    applyStimulus(80'h0, 1'b0, 0, 0, 1'b0, 1);

    $display("[TB] all-ones key, random ready");
    buildModel(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    applyStimulus(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 1'b0, 1);

    $display("[TB] stray start at K10");
    buildModel(80'h0);
    applyStimulus(80'h0, 1'b0, 10, 0, 1'b0, 1);

    $display("[TB] reset at K17, then restart");
    applyStimulus(80'h0, 1'b0, 0, 17, 1'b0, 1);
    buildModel(80'h0123_4567_89AB_CDEF_0123);
    applyStimulus(80'h0123_4567_89AB_CDEF_0123, 1'b0, 0, 0, 1'b0, 1);

`ifdef KSCHED_DECRYPT_EN
    $display("[TB] decrypt order, zero key");
    buildModel(80'h0);
    applyStimulus(80'h0, 1'b0, 0, 0, 1'b1, 32);
    buildModel(80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    applyStimulus(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 1'b1, 32);
    buildModel(80'h0);
    applyStimulus(80'h0, 1'b0, 0, 0, 1'b0, 1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
